// File: rtl/soc_system_sdram_pll_rst_seq.sv
// Reset/lock sequencer for the SDRAM PLL; SDRAM_PLL_RETRY_LIMIT_EN adds a terminal FAIL state.
// Latency: pll_locked reaches the FSM after 2 cycles; every output follows its state 1 cycle later.
// No backpressure: free-running level sequencer on the PLL reference clock.
module soc_system_sdram_pll_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 17,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sdram_reset_n,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic       pll_fail
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  if (RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_cycles
    $error("sequencer cycle counts must be at least 1");
  end
  if (RST_CYCLES > 2**CNT_W || LOCK_TIMEOUT > 2**CNT_W || STABLE_CYCLES > 2**CNT_W) begin : g_bad_cnt_w
    $error("CNT_W too narrow for the configured cycle counts");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > 255) begin : g_bad_retries
    $error("MAX_RETRIES must be within 1..255");
  end

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
    , S_FAIL    = 3'd4
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lock_meta;
  logic             lk;
  logic             timeout;
  logic             lost_evt;
  logic             retry_evt;
  logic             retry_evt_q;
  logic             lost_evt_q;
  logic             give_up;
  logic             fail_st;

  // pll_locked comes from the PLL's own clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lk        <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lk        <= lock_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RESET_PLL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    timeout   = 1'b0;
    lost_evt  = 1'b0;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // a lock seen on the timeout cycle still counts as a lock
        if (lk) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout   = 1'b1;
          state_nxt = S_RESET_PLL;
          cnt_nxt   = '0;
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
          if (give_up) state_nxt = S_FAIL;
`endif
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = '0;
        if (!lk) begin
          state_nxt = S_RESET_PLL;
          lost_evt  = 1'b1;
        end
      end
`ifdef SDRAM_PLL_RETRY_LIMIT_EN
      S_FAIL: begin
        cnt_nxt = '0;
      end
`endif
      default: begin
        state_nxt = S_RESET_PLL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // only a timeout that actually re-pulses the PLL is a retry
  assign retry_evt = timeout & (state_nxt == S_RESET_PLL);

`ifdef SDRAM_PLL_RETRY_LIMIT_EN
  logic [7:0] cons_cnt;

  assign give_up = (cons_cnt == 8'(MAX_RETRIES - 1));
  assign fail_st = (state == S_FAIL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cons_cnt <= '0;
    end else if (state == S_WAIT_LOCK && lk) begin
      cons_cnt <= '0;
    end else if (timeout && !give_up) begin
      cons_cnt <= cons_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_fail <= 1'b0;
    end else begin
      pll_fail <= fail_st;
    end
  end
`else
  assign give_up  = 1'b0;
  assign fail_st  = 1'b0;
  assign pll_fail = 1'b0;
`endif

  // events are delayed one cycle so the sticky/count outputs line up with the others
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst       <= 1'b1;
      sdram_reset_n <= 1'b0;
      pll_ready     <= 1'b0;
      lock_lost     <= 1'b0;
      retry_count   <= '0;
      retry_evt_q   <= 1'b0;
      lost_evt_q    <= 1'b0;
    end else begin
      retry_evt_q   <= retry_evt;
      lost_evt_q    <= lost_evt;
      pll_rst       <= (state == S_RESET_PLL) | fail_st;
      sdram_reset_n <= (state == S_RUN);
      pll_ready     <= (state == S_RUN);
      if (lost_evt_q) lock_lost <= 1'b1;
      if (retry_evt_q && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
    end
  end

endmodule
